// File: rtl/approx_adder_err_sweeper.sv
// approx_adder_err_sweeper
//   Exhaustive error characterisation of an approximate ripple-carry adder.
//   The low APPROX_CELLS cells are approximate (S = X | ~Cin, Cout = ~Cin) and
//   the remaining cells are exact full adders. A start pulse sweeps every
//   (in1, in2) operand pair, one pair per cycle, through a 2-stage pipeline.
//   The result of each pair is compared with the exact sum, and max / sum /
//   count error statistics are accumulated.
// Ports:
//   clk, rst   : clock (rising edge), synchronous active-high reset
//   start      : one-cycle pulse that begins a sweep (ignored unless idle)
//   hold       : stall; freezes the FSM, the counters, the pipeline and the accumulators
//   busy       : sweep in progress
//   done       : one-cycle pulse when the statistics are final
//   max_err    : largest |approx - exact|
//   worst_in1/2: operands of the first pair that reached max_err
//   err_sum    : sum of |approx - exact| over all pairs
//   err_cnt    : number of pairs with a nonzero error
module approx_adder_err_sweeper #(
  parameter int WIDTH        = 8,
  parameter int APPROX_CELLS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 hold,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH:0]       max_err,
  output logic [WIDTH-1:0]     worst_in1,
  output logic [WIDTH-1:0]     worst_in2,
  output logic [3*WIDTH:0]     err_sum,
  output logic [2*WIDTH:0]     err_cnt
);

  // Bit i set means cell i is an approximate cell.
  localparam logic [WIDTH:0] APX_MASK =
    ((WIDTH+1)'(1) << APPROX_CELLS) - (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] in1_cnt, in2_cnt;
  logic             last_pair;
  logic             accept;

  // Stage 1 registers
  logic             s1_v;
  logic [WIDTH:0]   s1_apx;
  logic [WIDTH:0]   s1_ex;
  logic [WIDTH-1:0] s1_in1, s1_in2;

  // Stage 2 valid: set in the cycle after stage 2 has consumed a pair
  logic             s2_v;

  logic [WIDTH:0]   apx_sum;
  logic [WIDTH:0]   ex_sum;
  logic [WIDTH:0]   abs_err;
  logic             carry;

  assign last_pair = (&in1_cnt) & (&in2_cnt);
  assign accept    = (state == S_IDLE) && start && !hold;

  // Approximate adder on the current counter values.
  always_comb begin
    apx_sum = '0;
    carry   = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (APX_MASK[i]) begin
        apx_sum[i] = in1_cnt[i] | ~carry;
        carry      = ~carry;
      end else begin
        apx_sum[i] = in1_cnt[i] ^ in2_cnt[i] ^ carry;
        carry      = (in1_cnt[i] & in2_cnt[i]) | (carry & (in1_cnt[i] ^ in2_cnt[i]));
      end
    end
    apx_sum[WIDTH] = carry;
  end

  assign ex_sum = {1'b0, in1_cnt} + {1'b0, in2_cnt};

  // Both operands are non-negative, so an unsigned compare-and-subtract gives
  // the same magnitude as the wider signed difference.
  always_comb begin
    abs_err = '0;
    if (s1_apx >= s1_ex) abs_err = s1_apx - s1_ex;
    else                 abs_err = s1_ex - s1_apx;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst)        state <= S_IDLE;
    else if (!hold) state <= state_nx;
  end

  // FSM next state and outputs
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nx = S_SWEEP;
      end
      S_SWEEP: begin
        busy = 1'b1;
        if (last_pair) state_nx = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!s1_v && !s2_v) state_nx = S_DONE;
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Counters, pipeline and accumulators
  always_ff @(posedge clk) begin
    if (rst) begin
      in1_cnt   <= '0;
      in2_cnt   <= '0;
      s1_v      <= 1'b0;
      s1_apx    <= '0;
      s1_ex     <= '0;
      s1_in1    <= '0;
      s1_in2    <= '0;
      s2_v      <= 1'b0;
      max_err   <= '0;
      worst_in1 <= '0;
      worst_in2 <= '0;
      err_sum   <= '0;
      err_cnt   <= '0;
    end else if (!hold) begin
      s1_v <= (state == S_SWEEP);
      s2_v <= s1_v;

      if (state == S_SWEEP) begin
        s1_apx  <= apx_sum;
        s1_ex   <= ex_sum;
        s1_in1  <= in1_cnt;
        s1_in2  <= in2_cnt;
        in2_cnt <= in2_cnt + 1'b1;
        if (&in2_cnt) in1_cnt <= in1_cnt + 1'b1;
      end

      if (accept) begin
        in1_cnt   <= '0;
        in2_cnt   <= '0;
        max_err   <= '0;
        worst_in1 <= '0;
        worst_in2 <= '0;
        err_sum   <= '0;
        err_cnt   <= '0;
      end else if (s1_v) begin
        if (abs_err > max_err) begin
          max_err   <= abs_err;
          worst_in1 <= s1_in1;
          worst_in2 <= s1_in2;
        end
        err_sum <= err_sum + {{(2*WIDTH){1'b0}}, abs_err};
        err_cnt <= err_cnt + {{(2*WIDTH){1'b0}}, (abs_err != '0)};
      end
    end
  end

endmodule
